// File: rtl/uart_line_arbiter.sv
// Line-atomic round-robin arbiter that lets NREQ byte streams share one print sink.
// Each owner keeps the sink until it sends CR/LF or stalls long enough to be cut off.

module uart_arb_lane #(
  parameter int IDW  = 2,
  parameter int LANE = 0
) (
  input  logic           own,
  input  logic [IDW-1:0] grant,
  input  logic [7:0]     data,
  input  logic           valid,
  output logic           ready,
  output logic [7:0]     data_o,
  output logic           hs_o
);
  logic sel;

  assign sel    = own && (grant == IDW'(LANE));
  assign ready  = sel;
  assign data_o = sel ? data : 8'h00;
  assign hs_o   = sel & valid;
endmodule

module uart_line_arbiter #(
  parameter int NREQ    = 4,
  parameter int GAP     = 0,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ*8-1:0]       req_data,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  output logic [7:0]              uart_data,
  output logic                    uart_data_valid,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    timeout_evt
);
  localparam int IDW = $clog2(NREQ);
  localparam int GW  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] GAP_LAST = (GAP > 0) ? 32'(GAP - 1) : 32'd0;
  localparam logic [31:0] TO_LAST  = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_GAP, S_FLUSH} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       vld;
    logic       evt;
  } uart_out_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] last_q, last_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [TW-1:0]  to_q, to_d;
  logic           rel_q, rel_d;
  uart_out_t      out_q, out_d;

  logic [NREQ-1:0][7:0] req_bytes;
  logic [NREQ-1:0][7:0] lane_data;
  logic [NREQ-1:0]      lane_hs;
  logic [7:0]           sel_byte;
  logic                 hs, own, term;
  logic [31:0]          to_inc;

  assign req_bytes = req_data;
  assign own       = (state_q == S_OWN);

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    uart_arb_lane #(.IDW(IDW), .LANE(g)) u_lane (
      .own    (own),
      .grant  (grant_q),
      .data   (req_bytes[g]),
      .valid  (req_valid[g]),
      .ready  (req_ready[g]),
      .data_o (lane_data[g]),
      .hs_o   (lane_hs[g])
    );
  end

  // Only the owning lane passes its byte, so an OR-reduce is the mux.
  always_comb begin
    sel_byte = 8'h00;
    for (int i = 0; i < NREQ; i++) sel_byte = sel_byte | lane_data[i];
  end

  assign hs     = |lane_hs;
  assign term   = (sel_byte == 8'h0A) || (sel_byte == 8'h0D);
  assign to_inc = 32'(to_q) + 32'd1;

  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IDW-1:0]  last);
    logic [IDW-1:0] w;
    logic           found;
    int             idx;
    w     = last;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && v[idx]) begin
        found = 1'b1;
        w     = IDW'(idx);
      end
    end
    return w;
  endfunction

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    gap_d     = gap_q;
    to_d      = to_q;
    rel_d     = rel_q;
    out_d     = out_q;
    out_d.vld = 1'b0;
    out_d.evt = 1'b0;
    case (state_q)
      S_IDLE: begin
        to_d  = '0;
        gap_d = '0;
        if (|req_valid) begin
          grant_d = rr_pick(req_valid, last_q);
          state_d = S_OWN;
        end
      end
      S_OWN: begin
        if (hs) begin
          out_d.data = sel_byte;
          out_d.vld  = 1'b1;
          to_d       = '0;
          if (term) last_d = grant_q;
          if (GAP > 0) begin
            state_d = S_GAP;
            rel_d   = term;
            gap_d   = '0;
          end else if (term) begin
            state_d = S_IDLE;
          end
        end else begin
          to_d = to_q + TW'(1);
          if (TIMEOUT > 0 && to_inc >= TO_LAST) state_d = S_FLUSH;
        end
      end
      S_GAP: begin
        if (32'(gap_q) == GAP_LAST) begin
          if (rel_q) begin
            state_d = S_IDLE;
            last_d  = grant_q;
          end else begin
            state_d = S_OWN;
            to_d    = '0;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_FLUSH: begin
        // Close the stalled line so the next owner starts on a fresh one.
        out_d.data = 8'h0A;
        out_d.vld  = 1'b1;
        out_d.evt  = 1'b1;
        last_d     = grant_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= IDW'(NREQ - 1);
      gap_q   <= '0;
      to_q    <= '0;
      rel_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      rel_q   <= rel_d;
      out_q   <= out_d;
    end
  end

  assign uart_data       = out_q.data;
  assign uart_data_valid = out_q.vld;
  assign timeout_evt     = out_q.evt;
  assign grant_id        = grant_q;
  assign busy            = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_line_arbiter.sv
// Directed bench: one arbiter with no gap and an 8-cycle timeout, one with GAP=3.
module tb_uart_line_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a_data, g_data;
  logic [3:0]  a_valid, a_ready, g_valid, g_ready;
  logic [7:0]  a_udata, g_udata;
  logic        a_uvld, g_uvld, a_busy, g_busy, a_tevt, g_tevt;
  logic [1:0]  a_gid, g_gid;

  uart_line_arbiter #(.NREQ(4), .GAP(0), .TIMEOUT(8)) dut_a (
    .clk(clk), .reset(rst), .req_data(a_data), .req_valid(a_valid), .req_ready(a_ready),
    .uart_data(a_udata), .uart_data_valid(a_uvld), .grant_id(a_gid), .busy(a_busy),
    .timeout_evt(a_tevt));

  uart_line_arbiter #(.NREQ(4), .GAP(3), .TIMEOUT(0)) dut_g (
    .clk(clk), .reset(rst), .req_data(g_data), .req_valid(g_valid), .req_ready(g_ready),
    .uart_data(g_udata), .uart_data_valid(g_uvld), .grant_id(g_gid), .busy(g_busy),
    .timeout_evt(g_tevt));

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] strm [4][64];
  int         slen [4];
  int         spos [4];
  logic [7:0] log_d [128];
  logic [1:0] log_g [128];
  int         nlog;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid = '0; a_data = '0;
    g_valid = '0; g_data = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic load_lines(input int nr, input int nl);
    for (int i = 0; i < 4; i++) begin
      slen[i] = 0;
      spos[i] = 0;
    end
    for (int i = 0; i < nr; i++) begin
      for (int l = 0; l < nl; l++) begin
        strm[i][2*l]   = 8'(65 + i);
        strm[i][2*l+1] = 8'h0A;
      end
      slen[i] = 2 * nl;
    end
  endtask

  task automatic a_drive();
    for (int i = 0; i < 4; i++) begin
      if (spos[i] < slen[i]) begin
        a_valid[i]       = 1'b1;
        a_data[i*8 +: 8] = strm[i][spos[i]];
      end else begin
        a_valid[i]       = 1'b0;
        a_data[i*8 +: 8] = 8'h00;
      end
    end
  endtask

  // Handshake is judged from the values that will be present at the next edge.
  task automatic a_run(input int ncyc);
    logic [3:0] hs;
    nlog = 0;
    a_drive();
    for (int c = 0; c < ncyc; c++) begin
      hs = a_valid & a_ready;
      step();
      for (int i = 0; i < 4; i++) if (hs[i]) spos[i]++;
      a_drive();
      if (a_uvld && nlog < 128) begin
        log_d[nlog] = a_udata;
        log_g[nlog] = a_gid;
        nlog++;
      end
    end
  endtask

  task automatic check_lines(input string tag, input int nr, input int nlines);
    chk($sformatf("%s_count", tag), 32'(nlog), 32'(2 * nlines));
    for (int k = 0; k < nlines; k++) begin
      if (2*k+1 < nlog) begin
        chk($sformatf("%s_char%0d", tag, k), 32'(log_d[2*k]), 32'(65 + k % nr));
        chk($sformatf("%s_gid%0d", tag, k), 32'(log_g[2*k]), 32'(k % nr));
        chk($sformatf("%s_term%0d", tag, k), 32'(log_d[2*k+1]), 32'h0A);
        chk($sformatf("%s_tgid%0d", tag, k), 32'(log_g[2*k+1]), 32'(k % nr));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_vld", 32'(a_uvld), 0);
    chk("rst_data", 32'(a_udata), 0);
    chk("rst_gid", 32'(a_gid), 0);
    chk("rst_ready", 32'(a_ready), 0);
    chk("rst_tevt", 32'(a_tevt), 0);
    chk("rst_g_busy", 32'(g_busy), 0);
    chk("rst_g_ready", 32'(g_ready), 0);
    step();
    chk("idle_busy", 32'(a_busy), 0);

    // Requester 2 sends "AB\n" back-to-back
    do_reset();
    a_valid[2] = 1'b1; a_data[23:16] = 8'h41;
    step();
    chk("t1_gid", 32'(a_gid), 2);
    chk("t1_busy", 32'(a_busy), 1);
    chk("t1_ready", 32'(a_ready), 32'h4);
    chk("t1_novld", 32'(a_uvld), 0);
    step();
    chk("t1_vA", 32'(a_uvld), 1);
    chk("t1_dA", 32'(a_udata), 32'h41);
    a_data[23:16] = 8'h42;
    step();
    chk("t1_vB", 32'(a_uvld), 1);
    chk("t1_dB", 32'(a_udata), 32'h42);
    a_data[23:16] = 8'h0A;
    step();
    chk("t1_vLF", 32'(a_uvld), 1);
    chk("t1_dLF", 32'(a_udata), 32'h0A);
    chk("t1_busy_lo", 32'(a_busy), 0);
    a_valid = '0;
    step();
    chk("t1_vld_lo", 32'(a_uvld), 0);
    chk("t1_hold", 32'(a_udata), 32'h0A);
    chk("t1_gid_hold", 32'(a_gid), 2);

    // Two requesters alternate whole lines
    do_reset();
    load_lines(2, 3);
    a_run(25);
    check_lines("alt", 2, 6);

    // GAP=3: requester 1 sends "hi\r"
    do_reset();
    g_valid[1] = 1'b1; g_data[15:8] = 8'h68;
    step();
    chk("gap_gid", 32'(g_gid), 1);
    chk("gap_ready0", 32'(g_ready), 32'h2);
    step();
    chk("gap_vh", 32'(g_uvld), 1);
    chk("gap_dh", 32'(g_udata), 32'h68);
    chk("gap_rdy_h", 32'(g_ready), 0);
    g_data[15:8] = 8'h69;
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("gap1_vld%0d", j), 32'(g_uvld), 0);
      chk($sformatf("gap1_rdy%0d", j), 32'(g_ready), (j < 2) ? 32'h0 : 32'h2);
    end
    step();
    chk("gap_vi", 32'(g_uvld), 1);
    chk("gap_di", 32'(g_udata), 32'h69);
    chk("gap_rdy_i", 32'(g_ready), 0);
    g_data[15:8] = 8'h0D;
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("gap2_vld%0d", j), 32'(g_uvld), 0);
      chk($sformatf("gap2_rdy%0d", j), 32'(g_ready), (j < 2) ? 32'h0 : 32'h2);
    end
    step();
    chk("gap_vcr", 32'(g_uvld), 1);
    chk("gap_dcr", 32'(g_udata), 32'h0D);
    chk("gap_busy_cr", 32'(g_busy), 1);
    g_valid = '0;
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("gap3_vld%0d", j), 32'(g_uvld), 0);
      chk($sformatf("gap3_busy%0d", j), 32'(g_busy), (j < 2) ? 32'h1 : 32'h0);
    end

    // Timeout: requester 3 sends 'Z' then stalls, requester 0 waits
    do_reset();
    a_valid[3] = 1'b1; a_data[31:24] = 8'h5A;
    step();
    chk("to_gid3", 32'(a_gid), 3);
    a_valid[0] = 1'b1; a_data[7:0] = 8'h71;
    step();
    chk("to_vZ", 32'(a_uvld), 1);
    chk("to_dZ", 32'(a_udata), 32'h5A);
    a_valid[3] = 1'b0;
    for (int j = 0; j < 7; j++) begin
      step();
      chk($sformatf("to_wait_vld%0d", j), 32'(a_uvld), 0);
      chk($sformatf("to_wait_evt%0d", j), 32'(a_tevt), 0);
      chk($sformatf("to_wait_busy%0d", j), 32'(a_busy), 1);
    end
    step();
    chk("to_vLF", 32'(a_uvld), 1);
    chk("to_dLF", 32'(a_udata), 32'h0A);
    chk("to_evt", 32'(a_tevt), 1);
    chk("to_gid_lf", 32'(a_gid), 3);
    step();
    chk("to_evt_once", 32'(a_tevt), 0);
    chk("to_vld_lo", 32'(a_uvld), 0);
    chk("to_next_gid", 32'(a_gid), 0);
    chk("to_next_busy", 32'(a_busy), 1);

    // Asynchronous reset in the middle of requester 3's line
    do_reset();
    a_valid[3] = 1'b1; a_data[31:24] = 8'h51;
    step();
    chk("ar_gid3", 32'(a_gid), 3);
    step();
    chk("ar_vQ", 32'(a_uvld), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_vld", 32'(a_uvld), 0);
    chk("ar_data", 32'(a_udata), 0);
    chk("ar_busy", 32'(a_busy), 0);
    chk("ar_gid", 32'(a_gid), 0);
    chk("ar_ready", 32'(a_ready), 0);
    chk("ar_evt", 32'(a_tevt), 0);
    a_valid[0] = 1'b1; a_data[7:0] = 8'h52;
    step();
    chk("ar_held_vld", 32'(a_uvld), 0);
    rst = 1'b0;
    step();
    chk("ar_prio_gid", 32'(a_gid), 0);
    chk("ar_no_q", 32'(a_uvld), 0);
    a_valid = '0;

    // All four requesters continuously valid, 20 single-char lines
    do_reset();
    load_lines(4, 5);
    a_run(75);
    check_lines("rr4", 4, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
